// File: rtl/pc_fetch_unit_if.sv
// Bundle between the fetch front end and the pipeline around it.
// The pipeline drives the hazard and redirect requests. The fetch unit
// answers with the fetch address, the PC+4 value, the flush strobes,
// the interrupt acknowledge and the saved return address.
interface pc_fetch_unit_if;
  logic        datahazard;
  logic        illop;
  logic [31:0] id_pcplus;
  logic        id_jump;
  logic [25:0] id_target;
  logic        id_jr;
  logic [31:0] id_rs;
  logic        ex_branch;
  logic [31:0] ex_pcplus;
  logic [15:0] ex_imm16;
  logic        irq;
  logic [31:0] pc;
  logic [31:0] pcplus;
  logic        flush_ifid;
  logic        flush_idex;
  logic        irq_ack;
  logic [31:0] epc;

  // Pipeline / environment side: it issues the requests and consumes the fetch results.
  modport master (
    output datahazard, illop, id_pcplus, id_jump, id_target, id_jr, id_rs,
           ex_branch, ex_pcplus, ex_imm16, irq,
    input  pc, pcplus, flush_ifid, flush_idex, irq_ack, epc
  );

  // Fetch unit side.
  modport slave (
    input  datahazard, illop, id_pcplus, id_jump, id_target, id_jr, id_rs,
           ex_branch, ex_pcplus, ex_imm16, irq,
    output pc, pcplus, flush_ifid, flush_idex, irq_ack, epc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end. It owns the program counter and picks the
// next PC from these sources, highest priority first: reset, illegal-op
// trap, taken branch, interrupt, stall, jump, jump-register, then
// sequential. It also produces the IF/ID and ID/EX flush strobes and keeps
// the exception return address.
// Optional feature: define PC_FETCH_IRQ_EN to enable external interrupt
// handling. Without it, irq is ignored and irq_ack stays 0.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input logic           clk,
  input logic           reset,
  pc_fetch_unit_if.slave bus
);

  logic [31:0] pc_r;
  logic [31:0] epc_r;
  logic [31:0] pc_next;
  logic [31:0] epc_next;
  logic [31:0] pcplus_w;
  logic [31:0] branch_sum;
  logic [31:0] jump_target;
  logic        flush_ifid_w;
  logic        flush_idex_w;
  logic        irq_ack_w;
  logic        irq_take;

  // Bit 31 is the kernel-mode flag. The +4 increment and branch
  // arithmetic only wrap inside bits 30:0, so they never change mode.
  assign pcplus_w    = {pc_r[31], pc_r[30:0] + 31'd4};
  assign branch_sum  = bus.ex_pcplus + {{14{bus.ex_imm16[15]}}, bus.ex_imm16, 2'b00};
  assign jump_target = {bus.id_pcplus[31:28], bus.id_target, 2'b00};

`ifdef PC_FETCH_IRQ_EN
  logic irq_d;
  logic irq_pend;

  // An interrupt is taken only in user mode, and only when no trap, branch or stall competes for the slot.
  assign irq_take = irq_pend & ~pc_r[31] & ~bus.illop & ~bus.ex_branch & ~bus.datahazard;

  // Catch rising edges of irq. A request stays pending until it is taken. A new rise while one is pending merges into it.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_d    <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      irq_d    <= bus.irq;
      irq_pend <= irq_take ? 1'b0 : (irq_pend | (bus.irq & ~irq_d));
    end
  end
`else
  logic        irq_unused;
  logic [31:0] xadr_unused;
  assign irq_unused  = bus.irq;
  assign xadr_unused = XADR_PC;
  assign irq_take    = 1'b0;
`endif

  // Next-PC priority chain. The flush and ack strobes come out in the same cycle as the redirect decision.
  always_comb begin
    pc_next      = pcplus_w;
    epc_next     = epc_r;
    flush_ifid_w = 1'b0;
    flush_idex_w = 1'b0;
    irq_ack_w    = 1'b0;
    if (reset) begin
      pc_next  = RESET_PC;
      epc_next = 32'h0;
    end else if (bus.illop) begin
      pc_next      = ILLOP_PC;
      epc_next     = bus.id_pcplus;
      flush_ifid_w = 1'b1;
    end else if (bus.ex_branch) begin
      pc_next      = {bus.ex_pcplus[31], branch_sum[30:0]};
      flush_ifid_w = 1'b1;
      flush_idex_w = 1'b1;
    end else if (irq_take) begin
      pc_next      = XADR_PC;
      epc_next     = pc_r;
      flush_ifid_w = 1'b1;
      irq_ack_w    = 1'b1;
    end else if (bus.datahazard) begin
      pc_next = pc_r;
    end else if (bus.id_jump) begin
      pc_next      = jump_target;
      flush_ifid_w = 1'b1;
    end else if (bus.id_jr) begin
      pc_next      = bus.id_rs;
      flush_ifid_w = 1'b1;
    end
  end

  // PC and EPC registers. Reset is synchronous and returns the core to kernel mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r  <= RESET_PC;
      epc_r <= 32'h0;
    end else begin
      pc_r  <= pc_next;
      epc_r <= epc_next;
    end
  end

  assign bus.pc         = pc_r;
  assign bus.pcplus     = pcplus_w;
  assign bus.epc        = epc_r;
  assign bus.flush_ifid = flush_ifid_w;
  assign bus.flush_idex = flush_idex_w;
  assign bus.irq_ack    = irq_ack_w;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit. It walks a table of directed
// vectors. Each vector gives the inputs for one cycle, the strobes
// expected in that cycle, and the pc/epc expected after the clock edge.
// The interrupt sequence follows the PC_FETCH_IRQ_EN build setting.
module tb_pc_fetch_unit;

  typedef struct {
    string       name;
    logic        rst;
    logic        illop;
    logic        br;
    logic        dh;
    logic        jmp;
    logic        jr;
    logic        irq;
    logic [31:0] id_pcplus;
    logic [25:0] id_target;
    logic [31:0] id_rs;
    logic [31:0] ex_pcplus;
    logic [15:0] ex_imm16;
    logic        exp_fi;
    logic        exp_fx;
    logic        exp_ack;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
  } vec_t;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pc_fetch_unit_if bus ();

  pc_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input string name, input logic rst, input logic illop,
                              input logic br, input logic dh, input logic jmp, input logic jr,
                              input logic irq, input logic [31:0] id_pcplus,
                              input logic [25:0] id_target, input logic [31:0] id_rs,
                              input logic [31:0] ex_pcplus, input logic [15:0] ex_imm16,
                              input logic fi, input logic fx, input logic ack,
                              input logic [31:0] npc, input logic [31:0] nepc);
    vec_t v;
    v.name = name; v.rst = rst; v.illop = illop; v.br = br; v.dh = dh;
    v.jmp = jmp; v.jr = jr; v.irq = irq; v.id_pcplus = id_pcplus;
    v.id_target = id_target; v.id_rs = id_rs; v.ex_pcplus = ex_pcplus;
    v.ex_imm16 = ex_imm16; v.exp_fi = fi; v.exp_fx = fx; v.exp_ack = ack;
    v.exp_pc = npc; v.exp_epc = nepc;
    return v;
  endfunction

  function automatic logic [31:0] model_pcplus(input logic [31:0] p);
    return {p[31], p[30:0] + 31'd4};
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Drive on the falling edge, check the combinational strobes, then check the registered state just after the rising edge.
  task automatic apply_stimulus(input vec_t v);
    @(negedge clk);
    reset          = v.rst;
    bus.illop      = v.illop;
    bus.ex_branch  = v.br;
    bus.datahazard = v.dh;
    bus.id_jump    = v.jmp;
    bus.id_jr      = v.jr;
    bus.irq        = v.irq;
    bus.id_pcplus  = v.id_pcplus;
    bus.id_target  = v.id_target;
    bus.id_rs      = v.id_rs;
    bus.ex_pcplus  = v.ex_pcplus;
    bus.ex_imm16   = v.ex_imm16;
    #1;
    check_output({v.name, " flush_ifid"}, {31'h0, bus.flush_ifid}, {31'h0, v.exp_fi});
    check_output({v.name, " flush_idex"}, {31'h0, bus.flush_idex}, {31'h0, v.exp_fx});
    check_output({v.name, " irq_ack"}, {31'h0, bus.irq_ack}, {31'h0, v.exp_ack});
    @(posedge clk);
    #1;
    check_output({v.name, " pc"}, bus.pc, v.exp_pc);
    check_output({v.name, " pcplus"}, bus.pcplus, model_pcplus(v.exp_pc));
    check_output({v.name, " epc"}, bus.epc, v.exp_epc);
  endtask

  vec_t vecs[$];
  vec_t seq[$];

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b1;
    bus.illop      = 1'b0;
    bus.ex_branch  = 1'b0;
    bus.datahazard = 1'b0;
    bus.id_jump    = 1'b0;
    bus.id_jr      = 1'b0;
    bus.irq        = 1'b0;
    bus.id_pcplus  = 32'h0;
    bus.id_target  = 26'h0;
    bus.id_rs      = 32'h0;
    bus.ex_pcplus  = 32'h0;
    bus.ex_imm16   = 16'h0;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset pc", bus.pc, 32'h8000_0000);
    check_output("reset pcplus", bus.pcplus, 32'h8000_0004);
    check_output("reset flush_ifid", {31'h0, bus.flush_ifid}, 32'h0);
    check_output("reset flush_idex", {31'h0, bus.flush_idex}, 32'h0);
    check_output("reset irq_ack", {31'h0, bus.irq_ack}, 32'h0);
    check_output("reset epc", bus.epc, 32'h0);

    //                name          rst il br dh jp jr iq id_pcplus     target        id_rs         ex_pcplus     imm       fi fx ak next_pc       next_epc
    vecs.push_back(mk("free0",      0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h80000004, 32'h0));
    vecs.push_back(mk("free1",      0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h80000008, 32'h0));
    vecs.push_back(mk("free2",      0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h8000000C, 32'h0));
    vecs.push_back(mk("jr_user",    0, 0, 0, 0, 0, 1, 0, 32'h0,        26'h0,        32'h00400010, 32'h0,        16'h0,    1, 0, 0, 32'h00400010, 32'h0));
    vecs.push_back(mk("br_stall",   0, 0, 1, 1, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0040000C, 16'hFFFE, 1, 1, 0, 32'h00400004, 32'h0));
    vecs.push_back(mk("jmp_stall",  0, 0, 0, 1, 1, 0, 0, 32'h00400020, 26'h0100008,  32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h00400004, 32'h0));
    vecs.push_back(mk("jmp_go",     0, 0, 0, 0, 1, 0, 0, 32'h00400020, 26'h0100008,  32'h0,        32'h0,        16'h0,    1, 0, 0, 32'h00400020, 32'h0));
    vecs.push_back(mk("illop_br",   0, 1, 1, 0, 0, 0, 0, 32'h00400044, 26'h0,        32'h0,        32'h00400030, 16'h0004, 1, 0, 0, 32'h80000004, 32'h00400044));
    vecs.push_back(mk("seq_k",      0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h80000008, 32'h00400044));
    vecs.push_back(mk("jr_top",     0, 0, 0, 0, 0, 1, 0, 32'h0,        26'h0,        32'h7FFFFFFC, 32'h0,        16'h0,    1, 0, 0, 32'h7FFFFFFC, 32'h00400044));
    vecs.push_back(mk("wrap_user",  0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h00000000, 32'h00400044));
    vecs.push_back(mk("jr_ktop",    0, 0, 0, 0, 0, 1, 0, 32'h0,        26'h0,        32'hFFFFFFFC, 32'h0,        16'h0,    1, 0, 0, 32'hFFFFFFFC, 32'h00400044));
    vecs.push_back(mk("wrap_kern",  0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h80000000, 32'h00400044));
    vecs.push_back(mk("br_wrap_u",  0, 0, 1, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h7FFFFFF0, 16'h0010, 1, 1, 0, 32'h00000030, 32'h00400044));
    vecs.push_back(mk("br_wrap_k",  0, 0, 1, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h80000004, 16'hFFFE, 1, 1, 0, 32'hFFFFFFFC, 32'h00400044));
    vecs.push_back(mk("jmp_ovr_jr", 0, 0, 0, 0, 1, 1, 0, 32'hA0000000, 26'h3FFFFFF,  32'h12345678, 32'h0,        16'h0,    1, 0, 0, 32'hAFFFFFFC, 32'h00400044));
    vecs.push_back(mk("jr_stall",   0, 0, 0, 1, 0, 1, 0, 32'h0,        26'h0,        32'h12345678, 32'h0,        16'h0,    0, 0, 0, 32'hAFFFFFFC, 32'h00400044));
    vecs.push_back(mk("br_ovr_all", 0, 0, 1, 1, 1, 0, 0, 32'h00500000, 26'h0000001,  32'h0,        32'h00400000, 16'h0001, 1, 1, 0, 32'h00400004, 32'h00400044));
    vecs.push_back(mk("illop",      0, 1, 0, 0, 0, 0, 0, 32'h00401000, 26'h0,        32'h0,        32'h0,        16'h0,    1, 0, 0, 32'h80000004, 32'h00401000));
    vecs.push_back(mk("rst_busy",   1, 1, 0, 1, 0, 0, 0, 32'h00402000, 26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h80000000, 32'h0));
    vecs.push_back(mk("post_rst",   0, 0, 0, 0, 0, 0, 0, 32'h0,        26'h0,        32'h0,        32'h0,        16'h0,    0, 0, 0, 32'h80000004, 32'h0));

    foreach (vecs[i]) apply_stimulus(vecs[i]);

`ifdef PC_FETCH_IRQ_EN
    // Interrupt taken in user mode, masked in kernel mode, then taken after the return to user mode. A reset drops a pending request.
    seq.push_back(mk("irq_jr",      0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h00400100, 32'h0, 16'h0, 1, 0, 0, 32'h00400100, 32'h0));
    seq.push_back(mk("irq_rise",    0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400104, 32'h0));
    seq.push_back(mk("irq_take",    0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 1, 0, 1, 32'h80000008, 32'h00400104));
    seq.push_back(mk("irq_once",    0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h8000000C, 32'h00400104));
    seq.push_back(mk("irq_low",     0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h80000010, 32'h00400104));
    seq.push_back(mk("irq_k_rise",  0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h80000014, 32'h00400104));
    seq.push_back(mk("irq_k_mask",  0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h80000018, 32'h00400104));
    seq.push_back(mk("irq_kexit",   0, 0, 0, 0, 0, 1, 1, 32'h0, 26'h0, 32'h00400104, 32'h0, 16'h0, 1, 0, 0, 32'h00400104, 32'h00400104));
    seq.push_back(mk("irq_take2",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 1, 0, 1, 32'h80000008, 32'h00400104));
    seq.push_back(mk("irq_low2",    0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h8000000C, 32'h00400104));
    seq.push_back(mk("irq_pend3",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h80000010, 32'h00400104));
    seq.push_back(mk("irq_rst",     1, 0, 0, 1, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h80000000, 32'h0));
    seq.push_back(mk("irq_lost_jr", 0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h00400200, 32'h0, 16'h0, 1, 0, 0, 32'h00400200, 32'h0));
    seq.push_back(mk("irq_lost1",   0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400204, 32'h0));
    seq.push_back(mk("irq_lost2",   0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400208, 32'h0));
`else
    // With interrupts compiled out, irq pulses in user mode do nothing.
    seq.push_back(mk("noirq_jr",    0, 0, 0, 0, 0, 1, 0, 32'h0, 26'h0, 32'h00400100, 32'h0, 16'h0, 1, 0, 0, 32'h00400100, 32'h0));
    seq.push_back(mk("noirq_hi1",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400104, 32'h0));
    seq.push_back(mk("noirq_hi2",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400108, 32'h0));
    seq.push_back(mk("noirq_lo",    0, 0, 0, 0, 0, 0, 0, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h0040010C, 32'h0));
    seq.push_back(mk("noirq_hi3",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400110, 32'h0));
    seq.push_back(mk("noirq_hi4",   0, 0, 0, 0, 0, 0, 1, 32'h0, 26'h0, 32'h0,        32'h0, 16'h0, 0, 0, 0, 32'h00400114, 32'h0));
`endif

    foreach (seq[i]) apply_stimulus(seq[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
